// File: rtl/cpu_mpyunit_pkg.sv
// Shared CPU package for the multiply unit: opcode encodings, controller
// state encoding, default tag width and the result half-select helper.
package cpu_mpyunit_pkg;

  localparam logic [1:0] MPY_OP_LO  = 2'b00;
  localparam logic [1:0] MPY_OP_UHI = 2'b10;
  localparam logic [1:0] MPY_OP_SHI = 2'b11;

  localparam int MPY_TW_DEFAULT = 5;

  typedef enum logic [1:0] {
    ST_FLUSH = 2'b00,
    ST_IDLE  = 2'b01,
    ST_WAIT  = 2'b10,
    ST_DRAIN = 2'b11
  } mpy_state_t;

  // Pick the requested 32-bit half of a 64-bit product.
  function automatic logic [31:0] mpy_select(input logic [63:0] p, input logic hi);
    logic [31:0] r;
    if (hi) begin
      r = p[63:32];
    end else begin
      r = p[31:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/cpu_mpyunit_bigsmpy.sv
// 64-bit pipelined 32x32 multiplier. No reset and no cancel: a product
// launched with i_sync always emerges CLOCKS cycles later with o_sync.
// i_sgn selects a signed (two's complement) or unsigned multiply.
module bigsmpy #(
  parameter int CLOCKS = 5
) (
  input  logic        i_clk,
  input  logic        i_sync,
  input  logic        i_sgn,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_sync,
  output logic [63:0] o_p
);

  logic signed [63:0] ext_a;
  logic signed [63:0] ext_b;
  logic signed [63:0] full;
  logic [63:0]        p_pipe [0:CLOCKS-1];
  logic [CLOCKS-1:0]  s_pipe;

  // Sign-extend only for signed operations, then take the low 64 bits.
  assign ext_a = {{32{i_sgn & i_a[31]}}, i_a};
  assign ext_b = {{32{i_sgn & i_b[31]}}, i_b};
  assign full  = ext_a * ext_b;

  // Product and sync delay line, CLOCKS stages deep.
  always_ff @(posedge i_clk) begin
    p_pipe[0] <= full;
    s_pipe[0] <= i_sync;
    for (int i = 1; i < CLOCKS; i++) begin
      p_pipe[i] <= p_pipe[i-1];
      s_pipe[i] <= s_pipe[i-1];
    end
  end

  assign o_p    = p_pipe[CLOCKS-1];
  assign o_sync = s_pipe[CLOCKS-1];

endmodule

// File: rtl/cpu_mpyunit.sv
// Multiply-unit controller: launches one product at a time into bigsmpy,
// returns the selected half with tag and flags, and handles flush, drain
// of orphaned products and post-reset recovery.
// Optional watchdog: define MPYUNIT_TIMEOUT_EN.
module cpu_mpyunit
  import cpu_mpyunit_pkg::*;
#(
  parameter int CLOCKS = 5,
  parameter int TW     = MPY_TW_DEFAULT
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_ce,
  input  logic [1:0]    i_op,
  input  logic [31:0]   i_a,
  input  logic [31:0]   i_b,
  input  logic [TW-1:0] i_tag,
  input  logic          i_clear,
  output logic          o_busy,
  output logic          o_valid,
  output logic [31:0]   o_result,
  output logic [TW-1:0] o_tag,
  output logic          o_z,
  output logic          o_n,
  output logic          o_err
);

  localparam int            CW        = 4;
  localparam logic [CW-1:0] ZERO      = {CW{1'b0}};
  localparam logic [CW-1:0] ONE       = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] FLUSH_CNT = CW'(CLOCKS + 1);

  mpy_state_t    state;
  mpy_state_t    state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;

  logic [31:0]   a_r;
  logic [31:0]   b_r;
  logic [TW-1:0] tag_r;
  logic          sgn_r;
  logic          hi_r;
  logic          sync_r;

  logic          busy_r;
  logic          valid_r;
  logic [31:0]   result_r;
  logic [TW-1:0] otag_r;
  logic          z_r;
  logic          n_r;

  logic          accept;
  logic          deliver;
  logic          timeout;
  logic          m_sync;
  logic [63:0]   m_p;
  logic [31:0]   sel;

  bigsmpy #(.CLOCKS(CLOCKS)) u_mpy (
    .i_clk  (i_clk),
    .i_sync (sync_r),
    .i_sgn  (sgn_r),
    .i_a    (a_r),
    .i_b    (b_r),
    .o_sync (m_sync),
    .o_p    (m_p)
  );

  assign sel = mpy_select(m_p, hi_r);

`ifdef MPYUNIT_TIMEOUT_EN
  logic [CW-1:0] wd;
  logic [CW-1:0] wd_nx;
  logic          err_r;

  // Watchdog: cleared at launch, counts while a product is outstanding.
  always_comb begin
    wd_nx = wd;
    if (accept) begin
      wd_nx = ZERO;
    end else if ((state == ST_WAIT || state == ST_DRAIN) && wd != FLUSH_CNT) begin
      wd_nx = wd + ONE;
    end else begin
      wd_nx = wd;
    end
  end

  assign timeout = (state == ST_WAIT || state == ST_DRAIN) && !m_sync && (wd == FLUSH_CNT);

  // Watchdog counter and error strobe registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wd    <= ZERO;
      err_r <= 1'b0;
    end else begin
      wd    <= wd_nx;
      err_r <= timeout;
    end
  end

  assign o_err = err_r;
`else
  assign timeout = 1'b0;
  assign o_err   = 1'b0;
`endif

  // Next-state, counter and launch/deliver decisions.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    deliver  = 1'b0;
    case (state)
      ST_FLUSH: begin
        // Stale products from before reset are ignored while counting down.
        if (cnt == ZERO) begin
          state_nx = ST_IDLE;
        end else begin
          cnt_nx = cnt - ONE;
        end
      end
      ST_IDLE: begin
        if (i_ce && !i_clear) begin
          accept   = 1'b1;
          cnt_nx   = ONE;
          state_nx = ST_WAIT;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (timeout) begin
          cnt_nx   = FLUSH_CNT;
          state_nx = ST_FLUSH;
        end else if (m_sync) begin
          // A flush arriving with the product drops it.
          deliver  = !i_clear;
          cnt_nx   = ZERO;
          state_nx = ST_IDLE;
        end else if (i_clear) begin
          state_nx = ST_DRAIN;
        end else begin
          state_nx = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        if (timeout) begin
          cnt_nx   = FLUSH_CNT;
          state_nx = ST_FLUSH;
        end else if (m_sync) begin
          cnt_nx = cnt - ONE;
          if (cnt == ONE) begin
            state_nx = ST_IDLE;
          end else begin
            state_nx = ST_DRAIN;
          end
        end else begin
          state_nx = ST_DRAIN;
        end
      end
      default: begin
        cnt_nx   = FLUSH_CNT;
        state_nx = ST_FLUSH;
      end
    endcase
  end

  // State, counter and registered busy flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= ST_FLUSH;
      cnt    <= FLUSH_CNT;
      busy_r <= 1'b1;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      busy_r <= (state_nx != ST_IDLE);
    end
  end

  // Operand capture and one-cycle launch strobe into the multiplier.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_r    <= 32'h0;
      b_r    <= 32'h0;
      tag_r  <= {TW{1'b0}};
      sgn_r  <= 1'b0;
      hi_r   <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      sync_r <= accept;
      if (accept) begin
        a_r   <= i_a;
        b_r   <= i_b;
        tag_r <= i_tag;
        sgn_r <= (i_op == MPY_OP_SHI);
        hi_r  <= i_op[1];
      end
    end
  end

  // Result, tag and flags; held between strobes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_r  <= 1'b0;
      result_r <= 32'h0;
      otag_r   <= {TW{1'b0}};
      z_r      <= 1'b0;
      n_r      <= 1'b0;
    end else begin
      valid_r <= deliver;
      if (deliver) begin
        result_r <= sel;
        otag_r   <= tag_r;
        z_r      <= (sel == 32'h0);
        n_r      <= sel[31];
      end
    end
  end

  assign o_busy   = busy_r;
  assign o_valid  = valid_r;
  assign o_result = result_r;
  assign o_tag    = otag_r;
  assign o_z      = z_r;
  assign o_n      = n_r;

endmodule
